// File: rtl/gpio_pad_ctrl.sv
// Single GPIO pad: registered config/drive, 2-flop input sync, debounce, edge IRQ.
// Latency: in_val follows a stable pin change after db_len+3 edges; irq one edge after in_val.
module gpio_pad_ctrl #(
    parameter int DB_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_we,
    input  logic            cfg_dir,
    input  logic [1:0]      cfg_pull,
    input  logic [DB_W-1:0] cfg_db_len,
    input  logic [1:0]      cfg_irq_mode,
    input  logic            out_we,
    input  logic            out_val,
    input  logic            irq_clr,
    output logic            pad_din,
    output logic            pad_oen,
    output logic [1:0]      pad_pull,
    input  logic            pad_dout,
    output logic            in_val,
    output logic            irq
);

    logic [DB_W-1:0] db_len;
    logic [1:0]      irq_mode;
    logic [DB_W-1:0] cnt;
    logic            s1;
    logic            s2;
    logic            irq_pend;
    logic            upd;
    logic            rise;
    logic            fall;
    logic            set_pend;

    // >= rather than == so a shortened db_len takes effect on an in-flight count.
    always_comb begin
        upd      = pad_oen && (s2 != in_val) && (cnt >= db_len);
        rise     = upd && s2;
        fall     = upd && !s2;
        set_pend = (rise && irq_mode[0]) || (fall && irq_mode[1]);
    end

    // pad_oen doubles as the (inverted) direction register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pad_oen  <= 1'b1;
            pad_pull <= 2'b00;
            db_len   <= '0;
            irq_mode <= 2'b00;
            pad_din  <= 1'b0;
        end else begin
            if (cfg_we) begin
                pad_oen  <= ~cfg_dir;
                pad_pull <= cfg_dir ? 2'b00 : cfg_pull;
                db_len   <= cfg_db_len;
                irq_mode <= cfg_irq_mode;
            end
            if (out_we) begin
                pad_din <= out_val;
            end
        end
    end

    // Sync and debounce freeze while driving so a floating pad never leaks in.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            cnt    <= '0;
            in_val <= 1'b0;
        end else if (pad_oen) begin
            s1 <= pad_dout;
            s2 <= s1;
            if (s2 == in_val) begin
                cnt <= '0;
            end else if (upd) begin
                in_val <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + DB_W'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_pend <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (set_pend) begin
                irq_pend <= 1'b1;
            end else if (irq_clr) begin
                irq_pend <= 1'b0;
            end
            irq <= irq_pend;
        end
    end

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Bench for gpio_pad_ctrl: directed scenarios with literal expectations, then random traffic
// compared every cycle against a behavioural model of the pad.
module tb_gpio_pad_ctrl;
    localparam int DB_W = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            cfg_we;
    logic            cfg_dir;
    logic [1:0]      cfg_pull;
    logic [DB_W-1:0] cfg_db_len;
    logic [1:0]      cfg_irq_mode;
    logic            out_we;
    logic            out_val;
    logic            irq_clr;
    logic            pad_din;
    logic            pad_oen;
    logic [1:0]      pad_pull;
    logic            pad_dout;
    logic            in_val;
    logic            irq;

    int n_pass  = 0;
    int n_total = 0;

    gpio_pad_ctrl #(.DB_W(DB_W)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_dir(cfg_dir), .cfg_pull(cfg_pull),
        .cfg_db_len(cfg_db_len), .cfg_irq_mode(cfg_irq_mode), .out_we(out_we),
        .out_val(out_val), .irq_clr(irq_clr), .pad_din(pad_din), .pad_oen(pad_oen),
        .pad_pull(pad_pull), .pad_dout(pad_dout), .in_val(in_val), .irq(irq)
    );

    always #5 clk = ~clk;

    // Behavioural model: architectural state of the pad as the requirements describe it.
    bit         m_valid = 1'b0;
    bit         m_dir, m_din, m_in, m_pend, m_irq;
    bit [1:0]   m_pull, m_mode;
    int         m_len;
    bit         m_sync [2];   // pin history: [0] newest, [1] the level debounce looks at
    int         m_run;        // consecutive cycles the synced level has disagreed with in_val
    logic       pad_bit;

    always @(posedge clk) begin
        bit event_rise, event_fall;
        event_rise = 1'b0;
        event_fall = 1'b0;
        if (rst) begin
            m_valid = 1'b1;
            m_dir = 0; m_din = 0; m_in = 0; m_pend = 0; m_irq = 0;
            m_pull = 0; m_mode = 0; m_len = 0; m_sync[0] = 0; m_sync[1] = 0; m_run = 0;
        end else begin
            m_irq = m_pend;
            if (!m_dir) begin
                bit seen;
                seen = m_sync[1];
                m_sync[1] = m_sync[0];
                m_sync[0] = (pad_dout === 1'b1);
                if (seen == m_in) begin
                    m_run = 0;
                end else if (m_run >= m_len) begin
                    // disagreement has now lasted longer than the debounce length
                    event_rise = seen;
                    event_fall = !seen;
                    m_in  = seen;
                    m_run = 0;
                end else begin
                    m_run++;
                end
            end else begin
                m_run = 0;
            end
            if ((event_rise && m_mode[0]) || (event_fall && m_mode[1])) m_pend = 1'b1;
            else if (irq_clr) m_pend = 1'b0;
            if (cfg_we) begin
                m_dir = cfg_dir; m_pull = cfg_pull; m_len = int'(cfg_db_len); m_mode = cfg_irq_mode;
            end
            if (out_we) m_din = out_val;
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (m_valid)
            check("model", {2'b00, pad_din, pad_oen, pad_pull, in_val, irq},
                  {2'b00, m_din, !m_dir, (m_dir ? 2'b00 : m_pull), m_in, m_irq});
    end

    task automatic drive_pad();
        pad_dout = m_dir ? 1'bz : pad_bit;
    endtask

    task automatic set_pad(input logic b);
        pad_bit = b;
        drive_pad();
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            drive_pad();
        end
    endtask

    task automatic write_cfg(input logic dir, input logic [1:0] pull, input int len, input logic [1:0] mode);
        cfg_we = 1'b1; cfg_dir = dir; cfg_pull = pull;
        cfg_db_len = DB_W'(len); cfg_irq_mode = mode;
        tick();
        cfg_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        bit  found;
        bit  saw_high;
        int  hold;

        rst = 1'b0; cfg_we = 0; cfg_dir = 0; cfg_pull = 0; cfg_db_len = 0; cfg_irq_mode = 0;
        out_we = 0; out_val = 0; irq_clr = 0;
        set_pad(1'b0);
        @(negedge clk);

        // Reset with competing config and output writes
        rst = 1'b1; cfg_we = 1'b1; cfg_dir = 1'b1; cfg_pull = 2'b11; cfg_db_len = 5;
        cfg_irq_mode = 2'b11; out_we = 1'b1; out_val = 1'b1;
        tick(2);
        rst = 1'b0; cfg_we = 1'b0; out_we = 1'b0;
        check("reset_oen", {7'd0, pad_oen}, 8'd1);
        check("reset_din", {7'd0, pad_din}, 8'd0);
        check("reset_pull", {6'd0, pad_pull}, 8'd0);
        check("reset_inval_irq", {6'd0, in_val, irq}, 8'd0);

        // Output drive with a floating pad
        write_cfg(1'b1, 2'b10, 0, 2'b00);
        out_we = 1'b1; out_val = 1'b1;
        tick();
        out_we = 1'b0;
        check("drive_oen", {7'd0, pad_oen}, 8'd0);
        check("drive_pull", {6'd0, pad_pull}, 8'd0);
        check("drive_din", {7'd0, pad_din}, 8'd1);
        tick(8);
        check("drive_z_inval", {7'd0, in_val}, 8'd0);

        // Debounce latency N=3
        write_cfg(1'b0, 2'b10, 3, 2'b00);
        check("input_pull", {6'd0, pad_pull}, 8'h02);
        tick(4);
        set_pad(1'b1);
        found = 0; k = 0;
        for (int i = 1; i <= 20 && !found; i++) begin
            tick();
            if (in_val === 1'b1) begin found = 1; k = i; end
        end
        check("db_latency_n3", 8'(k), 8'd6);
        set_pad(1'b0);
        tick(12);
        check("db_fall_back", {7'd0, in_val}, 8'd0);

        // 3-cycle glitch must be rejected
        set_pad(1'b1);
        tick(3);
        set_pad(1'b0);
        saw_high = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (in_val !== 1'b0) saw_high = 1;
        end
        check("glitch_rejected", {7'd0, saw_high}, 8'd0);

        // Rising IRQ, persistence across a fall, then clear
        write_cfg(1'b0, 2'b10, 3, 2'b01);
        set_pad(1'b1);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (in_val === 1'b1) found = 1;
        end
        check("irq_rise_seen", {7'd0, found}, 8'd1);
        check("irq_lags_inval", {7'd0, irq}, 8'd0);
        tick();
        check("irq_set", {7'd0, irq}, 8'd1);
        set_pad(1'b0);
        tick(12);
        check("irq_held_after_fall", {6'd0, in_val, irq}, 8'h01);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        tick();
        check("irq_cleared", {7'd0, irq}, 8'd0);

        // Set/clear collision, N=0
        write_cfg(1'b0, 2'b10, 0, 2'b11);
        set_pad(1'b1);
        tick(2);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        check("n0_latency", {7'd0, in_val}, 8'd1);
        tick();
        check("collision_set_wins", {7'd0, irq}, 8'd1);

        // Reset in the middle of an N=7 count
        write_cfg(1'b0, 2'b00, 7, 2'b11);
        set_pad(1'b0);
        tick(6);
        check("mid_count_inval", {7'd0, in_val}, 8'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_db", {6'd0, in_val, irq}, 8'd0);
        set_pad(1'b1);
        tick(3);
        check("rst_len_zero", {7'd0, in_val}, 8'd1);

        // Random traffic against the model
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 299) == 0);
            cfg_we       = ($urandom_range(0, 15) == 0);
            cfg_dir      = ($urandom_range(0, 3) == 0);
            cfg_pull     = 2'($urandom_range(0, 3));
            cfg_db_len   = ($urandom_range(0, 3) == 0) ? DB_W'($urandom) : DB_W'($urandom_range(0, 4));
            cfg_irq_mode = 2'($urandom_range(0, 3));
            out_we       = ($urandom_range(0, 3) == 0);
            out_val      = 1'($urandom_range(0, 1));
            irq_clr      = ($urandom_range(0, 11) == 0);
            if (hold == 0) begin
                pad_bit = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 10);
            end
            hold--;
            drive_pad();
            tick();
        end
        rst = 1'b0; cfg_we = 1'b0; out_we = 1'b0; irq_clr = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
